sparc_ffu_vis_add_ctl: RTL and testbench



---
 rtl/sparc_ffu_vis_pkg.sv | 18 +
 rtl/sparc_ffu_part_add32.sv | 26 ++
 rtl/sparc_ffu_vis_add_ctl.sv | 147 ++++++++++++++
 tb/tb_sparc_ffu_vis_add_ctl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_ffu_vis_pkg.sv
// Shared definitions for the VIS partitioned add/subtract sequencer.
//   OP_*    : bit positions inside the 3-bit request opcode.
//   state_e : sequencer state encoding.
package sparc_ffu_vis_pkg;

  localparam int unsigned OP_W      = 3;
  localparam int unsigned OP_SIZE32 = 0;  // 1: 32-bit lanes, 0: 16-bit lanes
  localparam int unsigned OP_SUB    = 1;  // subtract (rs1 - rs2)
  localparam int unsigned OP_SINGLE = 2;  // single-word op, operands in [31:0]

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXE_LO = 2'd1,
    ST_EXE_HI = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage : sparc_ffu_vis_pkg

// File: rtl/sparc_ffu_part_add32.sv
// Shared 32-bit partitioned adder.
//   a, b  : 32-bit addends (caller pre-inverts b for subtract)
//   cin   : carry into the low lane, and into the upper lane in 16-bit mode
//   add32 : 1 = one 32-bit lane, 0 = two independent 16-bit lanes
//   z     : 32-bit sum, lane carry-outs discarded
module sparc_ffu_part_add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  input  logic        add32,
  output logic [31:0] z
);

  logic [16:0] sum_lo;
  logic        cin_hi;

  // Low lane keeps its carry so it can chain into the upper half in 32-bit mode.
  assign sum_lo = 17'(a[15:0]) + 17'(b[15:0]) + 17'(cin);

  // In 16-bit mode the upper lane restarts from cin, never the low lane's carry.
  assign cin_hi = add32 ? sum_lo[16] : cin;

  assign z[15:0]  = sum_lo[15:0];
  assign z[31:16] = a[31:16] + b[31:16] + 16'(cin_hi);

endmodule : sparc_ffu_part_add32

// File: rtl/sparc_ffu_vis_add_ctl.sv
// Sequencer for VIS fpadd/fpsub (16/32-bit lanes, single and double word)
// running one shared 32-bit partitioned adder once per word, low word first.
//   req_*  : issue handshake (op, operands, opaque tag)
//   flush  : kills the in-flight op and any pending result
//   res_*  : result handshake towards FRF writeback
//   busy   : sequencer not idle
module sparc_ffu_vis_add_ctl
  import sparc_ffu_vis_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [2:0]       req_op,
  input  logic [63:0]      req_rs1,
  input  logic [63:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [63:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [63:0]       rs1_q, rs1_d;
  logic [63:0]       rs2_q, rs2_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              res_vld_q, res_vld_d;
  logic [63:0]       res_data_q, res_data_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              use_hi;
  logic [31:0]       add_a, add_b_raw, add_b, add_z;

  // Ready in IDLE, or in DONE when the current result leaves this cycle.
  assign req_rdy = ~flush & ((state_q == ST_IDLE) |
                             ((state_q == ST_DONE) & res_rdy));
  assign accept  = req_vld & req_rdy;

  // Word select and subtract inversion for the shared adder.
  assign use_hi    = (state_q == ST_EXE_HI);
  assign add_a     = use_hi ? rs1_q[63:32] : rs1_q[31:0];
  assign add_b_raw = use_hi ? rs2_q[63:32] : rs2_q[31:0];
  assign add_b     = op_q[OP_SUB] ? ~add_b_raw : add_b_raw;

  sparc_ffu_part_add32 u_add (
    .a     (add_a),
    .b     (add_b),
    .cin   (op_q[OP_SUB]),
    .add32 (op_q[OP_SIZE32]),
    .z     (add_z)
  );

  // Next-state and output computation.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    tag_d      = tag_q;
    res_vld_d  = res_vld_q;
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;

    if (accept) begin
      op_d  = req_op;
      rs1_d = req_rs1;
      rs2_d = req_rs2;
      tag_d = req_tag;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXE_LO;
      end
      ST_EXE_LO: begin
        res_data_d[31:0] = add_z;
        if (op_q[OP_SINGLE]) begin
          res_data_d[63:32] = 32'd0;
          res_vld_d         = 1'b1;
          res_tag_d         = tag_q;
          state_d           = ST_DONE;
        end else begin
          state_d = ST_EXE_HI;
        end
      end
      ST_EXE_HI: begin
        res_data_d[63:32] = add_z;
        res_vld_d         = 1'b1;
        res_tag_d         = tag_q;
        state_d           = ST_DONE;
      end
      ST_DONE: begin
        if (res_rdy) begin
          res_vld_d = 1'b0;
          state_d   = accept ? ST_EXE_LO : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything; req_rdy is already low so nothing is accepted.
    if (flush) begin
      state_d   = ST_IDLE;
      res_vld_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      tag_q      <= '0;
      res_vld_q  <= 1'b0;
      res_data_q <= '0;
      res_tag_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      tag_q      <= tag_d;
      res_vld_q  <= res_vld_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
      busy_q     <= busy_d;
    end
  end

  assign res_vld  = res_vld_q;
  assign res_data = res_data_q;
  assign res_tag  = res_tag_q;
  assign busy     = busy_q;

endmodule : sparc_ffu_vis_add_ctl

// File: tb/tb_sparc_ffu_vis_add_ctl.sv
// Scoreboard bench for sparc_ffu_vis_add_ctl: directed VIS cases,
// backpressure, flush, async reset, then randomized ops with random res_rdy.
module tb_sparc_ffu_vis_add_ctl;

  localparam int unsigned TAG_W = 5;

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_vld;
  logic             req_rdy;
  logic [2:0]       req_op;
  logic [63:0]      req_rs1;
  logic [63:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             res_vld;
  logic             res_rdy;
  logic [63:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             busy;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   rr_random = 1'b0;

  sparc_ffu_vis_add_ctl #(.TAG_W(TAG_W)) dut (
    .rclk     (clk),
    .reset    (reset),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_op   (req_op),
    .req_rs1  (req_rs1),
    .req_rs2  (req_rs2),
    .req_tag  (req_tag),
    .flush    (flush),
    .res_vld  (res_vld),
    .res_rdy  (res_rdy),
    .res_data (res_data),
    .res_tag  (res_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: per-lane modular add/subtract; upper word zero for single ops.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] r;
    logic [31:0] aw, bw, rw;
    logic [15:0] x, y;
    r = '0;
    for (int w = 0; w < 2; w++) begin
      aw = a[w*32 +: 32];
      bw = b[w*32 +: 32];
      if (op[0]) begin
        rw = op[1] ? aw - bw : aw + bw;
      end else begin
        for (int l = 0; l < 2; l++) begin
          x = aw[l*16 +: 16];
          y = bw[l*16 +: 16];
          rw[l*16 +: 16] = op[1] ? x - y : x + y;
        end
      end
      if (!(w == 1 && op[2])) r[w*32 +: 32] = rw;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rr_random) res_rdy = ($urandom_range(0, 3) != 0);
  endtask

  // Present a request until accepted; push its expected result on acceptance.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tag, input logic [63:0] exp_data);
    exp_t e;
    bit   done = 1'b0;
    req_vld = 1'b1;
    req_op  = op;
    req_rs1 = a;
    req_rs2 = b;
    req_tag = tag;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        e.data = exp_data;
        e.tag  = tag;
        e.cyc  = cyc + (op[2] ? 2 : 3);
        sb.push_back(e);
        done = 1'b1;
      end
      tick();
    end
    req_vld = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: request tag %0d not accepted within 50 cycles", tag);
    end
  endtask

  // Monitor: compares the presented result against the scoreboard head.
  initial begin : monitor
    bit prev_vld;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_vld = 1'b0;
        continue;
      end
      if (res_vld) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_res: res_vld with data %h, none expected", res_data);
        end else begin
          chk("res_data", res_data, sb[0].data);
          chk("res_tag", 64'(res_tag), 64'(sb[0].tag));
          if (!prev_vld) chk("latency_cycle", 64'(cyc), 64'(sb[0].cyc));
          if (!flush) chk("req_rdy_in_done", 64'(req_rdy), 64'(res_rdy));
          if (res_rdy && !flush) void'(sb.pop_front());
        end
      end
      prev_vld = res_vld & ~res_rdy;
    end
  end

  initial begin : stim
    logic [2:0]  op;
    logic [63:0] a, b;
    reset   = 1'b1;
    req_vld = 1'b0;
    req_op  = '0;
    req_rs1 = '0;
    req_rs2 = '0;
    req_tag = '0;
    flush   = 1'b0;
    res_rdy = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_vld", 64'(res_vld), 64'd0);
    chk("rst_res_data", res_data, 64'd0);
    chk("rst_res_tag", 64'(res_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd1);
    reset = 1'b0;
    tick();

    // Directed cases with literal expectations.
    issue(3'b000, 64'h0001FFFF_7FFF0001, 64'h00010001_0001FFFF, 5'd1, 64'h00020000_80000000);
    repeat (4) tick();
    issue(3'b001, 64'h0001FFFF_7FFF0001, 64'h00010001_0001FFFF, 5'd2, 64'h00030000_80010000);
    repeat (4) tick();
    issue(3'b110, 64'hDEADBEEF_00050000, 64'hDEADBEEF_00030001, 5'd3, 64'h00000000_0002FFFF);
    repeat (4) tick();
    issue(3'b011, 64'h0, 64'h1, 5'd4, 64'h00000000_FFFFFFFF);
    repeat (4) tick();

    // Backpressure: hold the result for 4 cycles, then consume + accept together.
    res_rdy = 1'b0;
    issue(3'b000, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 5'd5,
          model(3'b000, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444));
    for (int i = 0; i < 20 && !res_vld; i++) tick();
    repeat (4) tick();
    res_rdy = 1'b1;
    issue(3'b011, 64'hFFFF_0000_0000_0000, 64'h0000_0001_0000_0001, 5'd6,
          model(3'b011, 64'hFFFF_0000_0000_0000, 64'h0000_0001_0000_0001));
    repeat (5) tick();

    // Flush in EXE_HI with a competing request.
    issue(3'b001, 64'h5, 64'h7, 5'd7, model(3'b001, 64'h5, 64'h7));
    tick();
    sb.delete();
    flush   = 1'b1;
    req_vld = 1'b1;
    req_op  = 3'b000;
    req_tag = 5'd8;
    @(negedge clk);
    chk("flush_req_rdy", 64'(req_rdy), 64'd0);
    tick();
    flush   = 1'b0;
    req_vld = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_res_vld", 64'(res_vld), 64'd0);
    repeat (4) tick();

    // Async reset during EXE_LO.
    issue(3'b000, 64'h9, 64'h3, 5'd9, model(3'b000, 64'h9, 64'h3));
    reset = 1'b1;
    sb.delete();
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_res_vld", 64'(res_vld), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Randomized ops with random consumer backpressure.
    rr_random = 1'b1;
    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      issue(op, a, b, 5'($urandom_range(0, 31)), model(op, a, b));
      repeat ($urandom_range(0, 3)) tick();
    end

    rr_random = 1'b0;
    res_rdy   = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sparc_ffu_vis_add_ctl
